// File: rtl/sig_mon_pkg.sv
// Shared types and constants for the signature-checkpoint monitor.
package sig_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StPass,
        StFail
    } mon_state_e;

    typedef logic [1:0] fail_code_t;

    localparam fail_code_t FAIL_NONE  = 2'b00;
    localparam fail_code_t FAIL_TMO   = 2'b01;
    localparam fail_code_t FAIL_ORDER = 2'b10;

    localparam int unsigned ELAPSED_W = 32;

endpackage

// File: rtl/sig_mon_sync.sv
// Two-flop synchroniser plus stability filter for the monitored signature bus.
module sig_mon_sync #(
    parameter int unsigned SIG_W = 16
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic [SIG_W-1:0] chk_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sync1_q, sync2_q, sig_q;

    // The filtered value only moves once both synchroniser stages agree.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sig_q   <= '0;
        end else begin
            sync1_q <= chk_i;
            sync2_q <= sync1_q;
            if (sync1_q == sync2_q) begin
                sig_q <= sync2_q;
            end
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/sig_checkpoint_mon.sv
// Ordered signature-checkpoint monitor with per-stage timeout.
// Optional out-of-order detection is enabled by defining SIG_MON_ORDER_CHK_EN.
module sig_checkpoint_mon
    import sig_mon_pkg::*;
#(
    parameter int unsigned SIG_W   = 16,
    parameter int unsigned NUM_STG = 4,
    parameter int unsigned TMO_W   = 24,
    localparam int unsigned STG_W  = $clog2(NUM_STG)
) (
    input  logic                     mclk,
    input  logic                     reset_n,
    input  logic                     cfg_en,
    input  logic [TMO_W-1:0]         cfg_tmo,
    input  logic [NUM_STG*SIG_W-1:0] exp_sig,
    input  logic [SIG_W-1:0]         chk_bits,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               fail_code,
    output logic [STG_W-1:0]         stg_idx,
    output logic [ELAPSED_W-1:0]     elapsed
);

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STG - 1);

    mon_state_e           state_q;
    logic                 en_q;
    logic [TMO_W-1:0]     tmr_q;
    logic                 busy_q, pass_q, fail_q;
    fail_code_t           fail_code_q;
    logic [STG_W-1:0]     stg_idx_q;
    logic [ELAPSED_W-1:0] elapsed_q;

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] cur_exp;
    logic             cur_match;
    logic             ord_err;

    sig_mon_sync #(
        .SIG_W (SIG_W)
    ) u_sync (
        .mclk    (mclk),
        .reset_n (reset_n),
        .chk_i   (chk_bits),
        .sig_o   (sig_q)
    );

    assign cur_exp   = exp_sig[stg_idx_q * SIG_W +: SIG_W];
    assign cur_match = (sig_q == cur_exp);

`ifdef SIG_MON_ORDER_CHK_EN
    // A code belonging to any later stage means firmware skipped a checkpoint.
    always_comb begin
        ord_err = 1'b0;
        for (int j = 0; j < int'(NUM_STG); j++) begin
            if (j > int'(stg_idx_q) && sig_q == exp_sig[j*SIG_W +: SIG_W]) begin
                ord_err = 1'b1;
            end
        end
    end
`else
    assign ord_err = 1'b0;
`endif

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            en_q        <= 1'b0;
            tmr_q       <= '0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FAIL_NONE;
            stg_idx_q   <= '0;
            elapsed_q   <= '0;
        end else begin
            en_q <= cfg_en;
            if (!cfg_en) begin
                state_q     <= StIdle;
                busy_q      <= 1'b0;
                pass_q      <= 1'b0;
                fail_q      <= 1'b0;
                fail_code_q <= FAIL_NONE;
                stg_idx_q   <= '0;
                elapsed_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (!en_q) begin
                            state_q   <= StWait;
                            busy_q    <= 1'b1;
                            stg_idx_q <= '0;
                            tmr_q     <= cfg_tmo;
                            elapsed_q <= '0;
                        end
                    end
                    StWait: begin
                        if (elapsed_q != '1) begin
                            elapsed_q <= elapsed_q + 1'b1;
                        end
                        // Match takes priority over both order error and expiry.
                        if (cur_match) begin
                            if (stg_idx_q == LAST_STG) begin
                                state_q <= StPass;
                                busy_q  <= 1'b0;
                                pass_q  <= 1'b1;
                            end else begin
                                stg_idx_q <= stg_idx_q + 1'b1;
                                tmr_q     <= cfg_tmo;
                            end
                        end else if (ord_err) begin
                            state_q     <= StFail;
                            busy_q      <= 1'b0;
                            fail_q      <= 1'b1;
                            fail_code_q <= FAIL_ORDER;
                        end else if (cfg_tmo != '0) begin
                            if (tmr_q < TMO_W'(2)) begin
                                state_q     <= StFail;
                                busy_q      <= 1'b0;
                                fail_q      <= 1'b1;
                                fail_code_q <= FAIL_TMO;
                            end else begin
                                tmr_q <= tmr_q - 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign stg_idx   = stg_idx_q;
    assign elapsed   = elapsed_q;

endmodule
